// File: rtl/vga_fb_scanout.sv
// Framebuffer scan-out: VGA timing generation, pixel fetch through a synchronous
// RAM read port with SCALE x SCALE pixel replication, and DAC pin drive.
module vga_fb_scanout #(
    parameter int BITS_PER_COLOUR_CHANNEL = 1,
    parameter int H_VISIBLE   = 640,
    parameter int H_FRONT     = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BACK      = 48,
    parameter int V_VISIBLE   = 480,
    parameter int V_FRONT     = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BACK      = 33,
    parameter int SCALE_SHIFT = 2
) (
    input  logic                                 CLK_50,
    input  logic                                 resetn,
    output logic [14:0]                          rd_addr,
    input  logic [3*BITS_PER_COLOUR_CHANNEL-1:0] rd_data,
    output logic                                 frame_tick,
    output logic                                 VGA_CLK,
    output logic                                 VGA_HS,
    output logic                                 VGA_VS,
    output logic                                 VGA_BLANK_N,
    output logic                                 VGA_SYNC,
    output logic [9:0]                           VGA_R,
    output logic [9:0]                           VGA_G,
    output logic [9:0]                           VGA_B
);

    localparam int BPC     = BITS_PER_COLOUR_CHANNEL;
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_VIS_C  = HW'(H_VISIBLE);
    localparam logic [HW-1:0] HS_START = HW'(H_VISIBLE + H_FRONT);
    localparam logic [HW-1:0] HS_END   = HW'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_VIS_C  = VW'(V_VISIBLE);
    localparam logic [VW-1:0] VS_START = VW'(V_VISIBLE + V_FRONT);
    localparam logic [VW-1:0] VS_END   = VW'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [14:0]   FB_W     = 15'(H_VISIBLE >> SCALE_SHIFT);

    logic          pix_en;
    logic [HW-1:0] hcount;
    logic [VW-1:0] vcount;
    logic          s1_vis, s1_hs, s1_vs;
    logic          vis_c, hs_c, vs_c;
    logic [14:0]   addr_next;

    // Replicate the channel's bit field MSB-first to fill the 10-bit DAC input.
    function automatic logic [9:0] expand(input logic [BPC-1:0] c);
        logic [9:0] r;
        r = '0;
        for (int i = 0; i < 10; i++)
            r[9-i] = c[BPC-1-(i % BPC)];
        return r;
    endfunction

    always_comb begin
        vis_c     = (hcount < H_VIS_C) && (vcount < V_VIS_C);
        hs_c      = ~((hcount >= HS_START) && (hcount < HS_END));
        vs_c      = ~((vcount >= VS_START) && (vcount < VS_END));
        addr_next = 15'(vcount >> SCALE_SHIFT) * FB_W + 15'(hcount >> SCALE_SHIFT);
    end

    assign VGA_SYNC = 1'b0;

    always_ff @(posedge CLK_50 or negedge resetn) begin
        if (!resetn) begin
            pix_en      <= 1'b0;
            VGA_CLK     <= 1'b0;
            frame_tick  <= 1'b0;
            hcount      <= '0;
            vcount      <= '0;
            rd_addr     <= '0;
            s1_vis      <= 1'b0;
            s1_hs       <= 1'b1;
            s1_vs       <= 1'b1;
            VGA_HS      <= 1'b1;
            VGA_VS      <= 1'b1;
            VGA_BLANK_N <= 1'b0;
            VGA_R       <= '0;
            VGA_G       <= '0;
            VGA_B       <= '0;
        end else begin
            pix_en  <= ~pix_en;
            VGA_CLK <= ~pix_en;
            // Counters are stable across the idle phase, so this lands on the (0,0) pix_en cycle.
            frame_tick <= ~pix_en && (hcount == '0) && (vcount == '0);
            if (pix_en) begin
                if (hcount == H_LAST) begin
                    hcount <= '0;
                    vcount <= (vcount == V_LAST) ? '0 : vcount + 1'b1;
                end else begin
                    hcount <= hcount + 1'b1;
                end
                if (vis_c)
                    rd_addr <= addr_next;
                s1_vis <= vis_c;
                s1_hs  <= hs_c;
                s1_vs  <= vs_c;
                // rd_data settled during the idle phase; syncs travel with it to avoid skew.
                VGA_HS      <= s1_hs;
                VGA_VS      <= s1_vs;
                VGA_BLANK_N <= s1_vis;
                VGA_R <= s1_vis ? expand(rd_data[3*BPC-1:2*BPC]) : '0;
                VGA_G <= s1_vis ? expand(rd_data[2*BPC-1:BPC])   : '0;
                VGA_B <= s1_vis ? expand(rd_data[BPC-1:0])       : '0;
            end
        end
    end

endmodule

// File: tb/tb_vga_fb_scanout.sv
// Scoreboard bench for vga_fb_scanout on a shrunken timing so whole frames fit in a short run.
module tb_vga_fb_scanout;

    localparam int HV = 32, HF = 4, HS = 8, HB = 4;
    localparam int VV = 16, VF = 2, VS = 2, VB = 2;
    localparam int HT = HV + HF + HS + HB;   // 48
    localparam int VT = VV + VF + VS + VB;   // 22
    localparam int FRAME_CYC = 2 * HT * VT;  // 2112 CLK_50
    localparam int FBW = HV / 4;             // 8
    localparam int MAX_ADDR = (VV / 4 - 1) * FBW + (FBW - 1);  // 31

    logic        CLK_50 = 1'b0;
    logic        resetn = 1'b0;
    logic [14:0] rd_addr;
    logic [2:0]  rd_data = '0;
    logic        frame_tick, VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC;
    logic [9:0]  VGA_R, VGA_G, VGA_B;

    logic [2:0]  mem [0:32767];
    logic [32:0] q[$];
    logic        mon_on = 1'b0;
    logic        seen_max = 1'b0;
    logic [14:0] last_addr = '0;
    int          total = 0, bad = 0, since = 0;

    vga_fb_scanout #(
        .BITS_PER_COLOUR_CHANNEL(1),
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .SCALE_SHIFT(2)
    ) dut (
        .CLK_50(CLK_50), .resetn(resetn), .rd_addr(rd_addr), .rd_data(rd_data),
        .frame_tick(frame_tick), .VGA_CLK(VGA_CLK), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS),
        .VGA_BLANK_N(VGA_BLANK_N), .VGA_SYNC(VGA_SYNC),
        .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B)
    );

    always #5 CLK_50 = ~CLK_50;

    always @(posedge CLK_50) rd_data <= mem[rd_addr];

    localparam logic [32:0] RST_PIX = {1'b1, 1'b1, 1'b0, 30'd0};

    // Pins expected while the counters sit at (h, v).
    function automatic logic [32:0] exp_pix(input int h, input int v);
        logic vis, hs, vs;
        logic [2:0] w;
        vis = (h < HV) && (v < VV);
        hs  = !((h >= HV + HF) && (h < HV + HF + HS));
        vs  = !((v >= VV + VF) && (v < VV + VF + VS));
        w   = vis ? mem[(v / 4) * FBW + (h / 4)] : 3'b000;
        return {hs, vs, vis, w[2] ? 10'h3FF : 10'h000,
                w[1] ? 10'h3FF : 10'h000, w[0] ? 10'h3FF : 10'h000};
    endfunction

    task automatic fill(input logic [2:0] val);
        for (int i = 0; i < 32768; i++) mem[i] = val;
    endtask

    // Reset the DUT, queue the expected pixel stream, release and let the monitor drain it.
    task automatic run_frames(input int frames);
        int budget;
        @(negedge CLK_50);
        resetn = 1'b0;
        mon_on = 1'b0;
        q.delete();
        q.push_back(RST_PIX);
        q.push_back(RST_PIX);
        for (int f = 0; f < frames; f++)
            for (int v = 0; v < VT; v++)
                for (int h = 0; h < HT; h++)
                    q.push_back(exp_pix(h, v));
        mon_on = 1'b1;
        repeat (3) @(negedge CLK_50);
        resetn = 1'b1;
        budget = frames * FRAME_CYC + 50;
        while (q.size() > 0 && budget > 0) begin
            @(posedge CLK_50);
            budget--;
        end
        total++;
        if (q.size() > 0) begin
            bad++;
            $display("FAIL drain_timeout: left=%0d required=0", q.size());
        end
        mon_on = 1'b0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: pixels on VGA_CLK-high samples, frame_tick cadence, address bound.
    always @(posedge CLK_50) begin
        logic [32:0] got, want;
        #1;
        if (!resetn) since = 0;
        else since++;
        if (resetn && (frame_tick || (since % FRAME_CYC == 1))) begin
            total++;
            if (frame_tick !== (since % FRAME_CYC == 1)) begin
                bad++;
                $display("FAIL frame_tick: got=%b required=%b since=%0d",
                         frame_tick, (since % FRAME_CYC == 1), since);
            end
        end
        if (rd_addr != last_addr) begin
            total++;
            if (rd_addr > 15'(MAX_ADDR)) begin
                bad++;
                $display("FAIL addr_bound: got=%0d required<=%0d", rd_addr, MAX_ADDR);
            end
            last_addr = rd_addr;
        end
        if (rd_addr == 15'(MAX_ADDR)) seen_max = 1'b1;
        if (mon_on && resetn && VGA_CLK && q.size() > 0) begin
            want = q.pop_front();
            got  = {VGA_HS, VGA_VS, VGA_BLANK_N, VGA_R, VGA_G, VGA_B};
            total++;
            if (got !== want || VGA_SYNC !== 1'b0) begin
                bad++;
                $display("FAIL pixel: got=%h sync=%b required=%h (left=%0d)",
                         got, VGA_SYNC, want, q.size());
            end
        end
    end

    initial begin
        fill(3'b000);
        // Single red word at address 0: 4x4 red block at the top-left, two frames.
        mem[0] = 3'b100;
        run_frames(2);

        // Bottom-right framebuffer pixel white.
        fill(3'b000);
        mem[MAX_ADDR] = 3'b111;
        seen_max = 1'b0;
        run_frames(1);
        chk("max_addr_seen", 32'(seen_max), 32'd1);

        // Every word white: blanking must still force black.
        fill(3'b111);
        run_frames(1);

        // Asynchronous reset mid-line, mid-frame, checked with no clock edge.
        fill(3'b111);
        fork
            run_frames(1);
        join_none
        repeat (HT * 2 * 9 + 60) @(posedge CLK_50);
        disable fork;
        mon_on = 1'b0;
        q.delete();
        @(negedge CLK_50);
        #2 resetn = 1'b0;
        #1;
        chk("rst_hs",    32'(VGA_HS),      32'd1);
        chk("rst_vs",    32'(VGA_VS),      32'd1);
        chk("rst_blank", 32'(VGA_BLANK_N), 32'd0);
        chk("rst_clk",   32'(VGA_CLK),     32'd0);
        chk("rst_tick",  32'(frame_tick),  32'd0);
        chk("rst_addr",  32'(rd_addr),     32'd0);
        chk("rst_rgb",   32'({VGA_R, VGA_G, VGA_B}), 32'd0);
        run_frames(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_fb_scanout.md
Name: vga_fb_scanout

Overview:
- Read side of the 160x120 pixel framebuffer; pixel writers fill it through (x, y, colour, plot).
- Generates 640x480@60 Hz VGA timing from CLK_50 using a 25 MHz pixel enable.
- Fetches each framebuffer pixel through a synchronous RAM read port, replicated 4x horizontally and 4x vertically.
- Drives the board VGA DAC pins with sync and blank aligned to the pixel data.

Parameters:
BITS_PER_COLOUR_CHANNEL, 1, bits per R/G/B channel in a framebuffer word; word width is 3*BITS_PER_COLOUR_CHANNEL.
H_VISIBLE, 640, H_FRONT, 16, H_SYNC, 96, H_BACK, 48: horizontal timing in pixel ticks (total 800).
V_VISIBLE, 480, V_FRONT, 10, V_SYNC, 2, V_BACK, 33: vertical timing in lines (total 525).
SCALE_SHIFT, 2: log2 of the screen-to-framebuffer scale factor.

Ports:
CLK_50  in  1  50 MHz system clock
resetn  in  1  asynchronous active-low reset
rd_addr  out  15  framebuffer read address, y*160+x, registered
rd_data  in  3*BITS_PER_COLOUR_CHANNEL  RAM output {R,G,B}, valid one CLK_50 after rd_addr changes
frame_tick  out  1  one-CLK_50 pulse at the start of each frame
VGA_CLK  out  1  25 MHz pixel clock to the DAC
VGA_HS  out  1  horizontal sync, active low
VGA_VS  out  1  vertical sync, active low
VGA_BLANK_N  out  1  low outside the visible area
VGA_SYNC  out  1  constant 0 (no sync-on-green)
VGA_R  out  10  red
VGA_G  out  10  green
VGA_B  out  10  blue

Behaviour:
- Reset values: pix_en=0; hcount=0; vcount=0; rd_addr=0; VGA_CLK=0; VGA_HS=1; VGA_VS=1; VGA_BLANK_N=0; R/G/B=0; frame_tick=0. Reset is asynchronous and takes effect mid-line or mid-frame; timing restarts at (0,0) on release.
- pix_en toggles every CLK_50. All counters and pipeline stages advance only on cycles with pix_en=1. VGA_CLK is registered ~pix_en, so its rising edge falls mid-data.
- hcount runs 0..799 and wraps to 0. vcount increments when hcount wraps and itself wraps 524->0.
- Stage 1, on a pix_en cycle:
  - rd_addr <= (vcount>>SCALE_SHIFT)*160 + (hcount>>SCALE_SHIFT), computed in 15 bits with no overflow (max 19199).
  - When outside the visible area, rd_addr holds its value.
  - Registered alongside it: visible = (hcount<640 && vcount<480); hs = ~(656<=hcount<752); vs = ~(490<=vcount<492).
- rd_data settles on the following CLK_50, where pix_en=0.
- Stage 2, on the next pix_en cycle:
  - Each channel is expanded to 10 bits by replicating its bit field MSB-first. With 1 bit per channel: 1->10'h3FF, 0->10'h000.
  - Expanded colour is forced to 0 when the stage-1 visible flag is 0.
  - VGA_HS, VGA_VS and VGA_BLANK_N take the stage-1 flags.
- Latency: counter value to pins is 2 pixel ticks (4 CLK_50), identical for data, syncs and blank. No sync/data skew is allowed.
- frame_tick is high for exactly one CLK_50, on the pix_en cycle where hcount=0 and vcount=0. It never fires during reset.
- rd_data is never sampled on a non-pix_en cycle. The block never writes the framebuffer and has no backpressure.

Test Plan:
- Reset release, run 2 frames -> VGA_HS period 1600 CLK_50 with low width 192 CLK_50. VGA_VS period 840000 CLK_50 with low width 2 lines. frame_tick pulses exactly twice, 840000 cycles apart.
- RAM model with word at address 0 = 3'b100 and all others 0 -> at the first visible pixel, VGA_R=10'h3FF and G/B=0 for 8 CLK_50 (4 pixels) on each of lines 0-3. Line 4 is black.
- Pixel (159,119) = 3'b111 -> white at screen columns 636-639, lines 476-479. rd_addr=19199 is observed; no address exceeds 19199.
- All RAM words = 3'b111 -> R/G/B are 0 whenever VGA_BLANK_N=0. VGA_BLANK_N goes low in the same cycle that the last visible white pixel ends.
- Alignment check: the first falling edge of VGA_HS occurs 4 CLK_50 after hcount reaches 656. The first VGA_BLANK_N rise of each line occurs 4 CLK_50 after hcount reaches 0.
- Assert resetn low mid-line (hcount=300, vcount=200) for 3 cycles -> outputs take reset values immediately with no clock. After release, the next frame_tick occurs 840000 cycles later, plus the pix_en phase offset.
